// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Computes the next PC for the pc
// register, issues in-order instruction-memory reads and buffers returned
// words with their PC in a DEPTH-entry in-order queue for decode. A redirect
// flushes the queue and arranges for in-flight responses to be discarded.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// imem_req_valid may drop without a transfer; imem_rsp_valid has no ready
// and is always consumed; inst_valid/inst_ready pops the head entry.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic [31:0] next_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   // queue storage
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [DEPTH-1:0] filled_next;

   // head: oldest entry, fill: oldest unfilled entry, tail: next free slot
   logic [PW-1:0] head_q;
   logic [PW-1:0] fill_q;
   logic [PW-1:0] tail_q;

   // count: allocated entries, pend: allocated but unfilled, drop: stale responses
   logic [CW-1:0] count_q;
   logic [CW-1:0] pend_q;
   logic [CW-1:0] drop_q;

   logic [CW:0]   occupancy;
   logic [CW-1:0] drop_sum;
   logic [CW-1:0] flush_drop;
   logic          accept;
   logic          pop;
   logic          rsp_drop;
   logic          rsp_fill;
   logic          unused_bits;

   // the low redirect target bits are defined as don't-care
   assign unused_bits = ^redirect_pc[1:0];

   assign occupancy      = {1'b0, count_q} + {1'b0, drop_q};
   assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = {pc_i[31:2], 2'b00};
   assign accept         = imem_req_valid && imem_req_ready;

   // head outputs come straight from registers: no response-to-decode bypass
   assign inst_valid = filled_q[head_q];
   assign inst_data  = data_q[head_q];
   assign inst_pc    = pc_q[head_q];
   assign pop        = inst_valid && inst_ready;

   // stale responses are consumed first; a response with nothing pending is ignored
   assign rsp_drop = imem_rsp_valid && (drop_q != '0);
   assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);

   // on a flush every unfilled entry becomes a response to discard, minus one
   // if that response is arriving right now (it is dropped in the same cycle)
   assign drop_sum   = drop_q + pend_q;
   assign flush_drop = (imem_rsp_valid && (drop_sum != '0)) ? drop_sum - CW'(1) : drop_sum;

   // next PC: reset, then redirect target, then sequential advance on accept, else hold
   always_comb begin
      next_pc = pc_i;
      if (rst)
         next_pc = RESET_PC;
      else if (redirect_valid)
         next_pc = {redirect_pc[31:2], 2'b00};
      else if (accept)
         next_pc = pc_i + 32'd4;
   end

   // filled flags: pop clears head, response sets fill slot, allocation clears tail
   always_comb begin
      filled_next = filled_q;
      if (pop)
         filled_next[head_q] = 1'b0;
      if (rsp_fill)
         filled_next[fill_q] = 1'b1;
      if (accept)
         filled_next[tail_q] = 1'b0;
   end

   // queue state: flush on redirect, otherwise allocate / fill / pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
         filled_q <= '0;
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         pend_q   <= '0;
         drop_q   <= '0;
      end else if (redirect_valid) begin
         filled_q <= '0;
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         pend_q   <= '0;
         drop_q   <= flush_drop;
      end else begin
         if (accept) begin
            pc_q[tail_q] <= imem_req_addr;
            tail_q       <= tail_q + PW'(1);
         end
         if (rsp_fill) begin
            data_q[fill_q] <= imem_rsp_data;
            fill_q         <= fill_q + PW'(1);
         end
         if (pop)
            head_q <= head_q + PW'(1);
         if (rsp_drop)
            drop_q <= drop_q - CW'(1);
         filled_q <= filled_next;
         count_q  <= count_q + CW'(accept) - CW'(pop);
         pend_q   <= pend_q + CW'(accept) - CW'(rsp_fill);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors for the next-PC / issue logic, directed
// sequences for the multi-cycle corners, and randomized traffic checked
// against a queue-level reference model of the fetch buffer.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic [31:0] next_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   // clock / reset
   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_i           (pc_i),
      .next_pc        (next_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   int checks = 0;
   int errors = 0;

   // reference model: fetch buffer as a queue plus a count of responses to discard
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      bit          filled;
   } ent_t;
   ent_t mq[$];
   int   mdrop;

   // memory model: in-order, fixed latency
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t memq[$];
   int    lat = 1;
   int    cyc = 0;

   // observed deliveries to decode
   logic [31:0] del_pc[$];
   int          del_cyc[$];
   int          acc_cnt;

   typedef struct {
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] pc;
      logic        rr;
      logic [31:0] exp_np;
      logic [31:0] exp_addr;
      logic        exp_rv;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      inst_ready     = 1'b0;
      pc_i           = RESET_PC;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_next_pc", next_pc, RESET_PC);
      rst = 1'b0;
      mq.delete();
      mdrop = 0;
      memq.delete();
      @(posedge clk);
      #1;
   endtask

   // one clock cycle: drive inputs, check against the model at the negedge, advance the model
   task automatic step(input logic rv, input logic [31:0] rpc, input logic rr, input logic ir);
      logic [31:0] exp_np;
      logic        exp_rv;
      logic        exp_iv;
      logic        acc;
      int          unf;
      bit          done;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = rr;
      inst_ready     = ir;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memq[0].addr ^ 32'hA5A5_0000;
         void'(memq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      exp_rv = !rv && (mq.size() + mdrop < DEPTH);
      exp_iv = (mq.size() > 0) && mq[0].filled;
      acc    = exp_rv && rr;
      exp_np = rv ? {rpc[31:2], 2'b00} : (acc ? pc_i + 32'd4 : pc_i);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("next_pc", next_pc, exp_np);
      chk("inst_valid", inst_valid, exp_iv);
      if (exp_rv)
         chk("req_addr", imem_req_addr, pc_i & 32'hFFFF_FFFC);
      if (exp_iv) begin
         chk("inst_pc", inst_pc, mq[0].pc);
         chk("inst_data", inst_data, mq[0].data);
      end
      if (imem_req_valid && imem_req_ready) begin
         memq.push_back('{imem_req_addr, cyc + lat});
         acc_cnt++;
      end
      if (inst_valid && inst_ready) begin
         del_pc.push_back(inst_pc);
         del_cyc.push_back(cyc);
      end
      if (exp_iv && ir)
         void'(mq.pop_front());
      if (rv) begin
         unf = 0;
         foreach (mq[i]) if (!mq[i].filled) unf++;
         mdrop = mdrop + unf - ((imem_rsp_valid && (mdrop + unf > 0)) ? 1 : 0);
         mq.delete();
      end else begin
         if (imem_rsp_valid) begin
            if (mdrop > 0) begin
               mdrop--;
            end else begin
               done = 0;
               for (int i = 0; i < mq.size(); i++) begin
                  if (!done && !mq[i].filled) begin
                     mq[i].data   = imem_rsp_data;
                     mq[i].filled = 1'b1;
                     done         = 1;
                  end
               end
            end
         end
         if (acc)
            mq.push_back('{pc_i & 32'hFFFF_FFFC, 32'h0, 1'b0});
      end
      @(posedge clk);
      #1;
      pc_i = exp_np;
      cyc++;
   endtask

   task automatic clear_log();
      del_pc.delete();
      del_cyc.delete();
      acc_cnt = 0;
   endtask

   // check that the first n deliveries are base, base+4, ...
   task automatic chk_seq(input string name, input logic [31:0] base, input int n);
      chk({name, "_count"}, 32'(del_pc.size() >= n), 32'd1);
      for (int i = 0; i < n; i++)
         if (i < del_pc.size())
            chk(name, del_pc[i], base + 32'(4 * i));
   endtask

   initial begin
      // next-PC priority and issue condition from a clean, empty queue
      vt[0] = '{1'b0, 1'b0, 32'h0,         32'h0000_0100, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b1};
      vt[1] = '{1'b0, 1'b0, 32'h0,         32'h0000_0100, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b1};
      vt[2] = '{1'b0, 1'b1, 32'h8000_0003, 32'h0000_0100, 1'b1, 32'h8000_0000, 32'h0000_0100, 1'b0};
      vt[3] = '{1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
      vt[4] = '{1'b1, 1'b0, 32'h0,         32'h0000_1234, 1'b1, RESET_PC,      32'h0000_1234, 1'b0};
      vt[5] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234, 1'b1, RESET_PC,      32'h0000_1234, 1'b0};
      vt[6] = '{1'b0, 1'b0, 32'h0,         32'h0000_0102, 1'b1, 32'h0000_0106, 32'h0000_0100, 1'b1};
      vt[7] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0000_0010, 1'b0};
      clear_log();
      for (int i = 0; i < 8; i++) begin
         do_reset();
         rst            = vt[i].r;
         redirect_valid = vt[i].rv;
         redirect_pc    = vt[i].rpc;
         pc_i           = vt[i].pc;
         imem_req_ready = vt[i].rr;
         #1;
         chk("vec_next_pc", next_pc, vt[i].exp_np);
         chk("vec_req_valid", imem_req_valid, vt[i].exp_rv);
         chk("vec_req_addr", imem_req_addr, vt[i].exp_addr);
      end

      // streaming with a 1-cycle memory: one instruction per cycle
      do_reset();
      lat = 1;
      clear_log();
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk_seq("t1_pc", 32'h0, 4);
      for (int i = 1; i < 4; i++)
         if (i < del_cyc.size())
            chk("t1_back_to_back", 32'(del_cyc[i] - del_cyc[0]), 32'(i));

      // decode stalled: queue fills, issue stops, then drains in order
      do_reset();
      clear_log();
      repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("t2_accepts", 32'(acc_cnt), 32'd4);
      chk("t2_req_held", imem_req_valid, 1'b0);
      chk("t2_pc_held", next_pc, pc_i);
      repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk_seq("t2_drain", 32'h0, 8);

      // memory ready toggling: PC advances only on accepts, stream stays contiguous
      do_reset();
      clear_log();
      repeat (6) begin
         step(1'b0, 32'h0, 1'b1, 1'b1);
         step(1'b0, 32'h0, 1'b0, 1'b1);
         step(1'b0, 32'h0, 1'b0, 1'b1);
         step(1'b0, 32'h0, 1'b1, 1'b1);
      end
      chk_seq("t3_pc", 32'h0, 8);

      // 3-cycle memory, redirect with two requests in flight
      do_reset();
      lat = 3;
      step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      clear_log();
      step(1'b1, 32'h8000_0003, 1'b1, 1'b1);
      repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk_seq("t4_target", 32'h8000_0000, 2);

      // redirect in the same cycle as a response and a pop (2-cycle memory)
      do_reset();
      lat = 2;
      repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("t5_head_ready", inst_valid, 1'b1);
      clear_log();
      step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
      chk("t5_pop_once", 32'(del_pc.size()), 32'd1);
      if (del_pc.size() > 0)
         chk("t5_popped_pc", del_pc[0], 32'h0000_001C);
      repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
      if (del_pc.size() > 1)
         chk("t5_first_after", del_pc[1], 32'h0000_4000);
      else
         chk("t5_first_after_count", 32'(del_pc.size()), 32'd2);

      // PC wrap at the top of the address space
      do_reset();
      lat = 1;
      pc_i = 32'hFFFF_FFFC;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("t6_wrap", pc_i, 32'h0000_0000);
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);

      // asynchronous reset in the middle of a stream
      do_reset();
      repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("t7_pre_valid", inst_valid, 32'((mq.size() > 0) && mq[0].filled));
      rst = 1'b1;
      #1;
      chk("t7_inst_valid", inst_valid, 1'b0);
      chk("t7_next_pc", next_pc, RESET_PC);
      chk("t7_req_valid", imem_req_valid, 1'b0);

      // randomized traffic against the reference model
      for (int l = 1; l <= 4; l++) begin
         do_reset();
         lat = l;
         repeat (150)
            step(($urandom_range(0, 15) == 0), $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
